// File: rtl/v_hier_qmon_pkg.sv
// v_hier_qmon_pkg: shared event layout, drop counter width and sampler states
package v_hier_qmon_pkg;
  localparam int DROP_W = 8;
  localparam int VALUE_LSB = 0;
  typedef enum logic {UNPRIMED = 1'b0, PRIMED = 1'b1} state_t;
  function automatic int mask_lsb(int width);
    return width;
  endfunction
  function automatic int ts_lsb(int width);
    return 2 * width;
  endfunction
endpackage

// File: rtl/v_hier_qmon_fifo.sv
// v_hier_qmon_fifo: show-ahead synchronous fifo, a pop frees a slot for a same-edge push
module v_hier_qmon_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_l,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    full = count == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/v_hier_qmon.sv
// v_hier_qmon: change monitor for qvec, timestamped events queued in a show-ahead fifo
module v_hier_qmon
  import v_hier_qmon_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TSW = 8
) (
  input  logic clk,
  input  logic reset_l,
  input  logic en,
  input  logic [WIDTH-1:0] qvec,
  input  logic clr_ovf,
  input  logic ev_ready,
  output logic ev_valid,
  output logic [TSW+2*WIDTH-1:0] ev_data,
  output logic [$clog2(DEPTH):0] count,
  output logic overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int EW = TSW + 2 * WIDTH;
  localparam int MASK_LSB = mask_lsb(WIDTH);
  localparam int TS_LSB = ts_lsb(WIDTH);
  state_t state, nstate;
  logic [WIDTH-1:0] prev, mask;
  logic [TSW-1:0] ts;
  logic [EW-1:0] rec;
  logic evt, drop, empty, full;
  always_comb begin
    nstate = en ? PRIMED : UNPRIMED;
    mask = qvec ^ prev;
    evt = en && state == PRIMED && |mask;
    drop = evt && full && !ev_ready;
    rec = '0;
    rec[VALUE_LSB +: WIDTH] = qvec;
    rec[MASK_LSB +: WIDTH] = mask;
    rec[TS_LSB +: TSW] = ts;
    ev_valid = !empty;
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) state <= UNPRIMED;
    else state <= nstate;
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      prev <= '0;
      ts <= '0;
    end else if (en) begin
      prev <= qvec;
      ts <= ts + 1'b1;
    end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_ovf ? DROP_W'(1) : (&drop_cnt ? drop_cnt : drop_cnt + 1'b1);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  v_hier_qmon_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_l(reset_l),
    .push(evt),
    .pop(ev_ready),
    .din(rec),
    .dout(ev_data),
    .empty(empty),
    .full(full),
    .count(count)
  );
endmodule

// File: tb/tb_v_hier_qmon.sv
// tb_v_hier_qmon: randomized and directed checks of v_hier_qmon against a queue model
module tb_v_hier_qmon;
  localparam int W = 4, D = 4, T = 8, EW = T + 2 * W;
  logic clk = 0, reset_l = 1, en = 0, clr_ovf = 0, ev_ready = 0;
  logic [W-1:0] qvec = '0;
  logic ev_valid, overflow;
  logic [EW-1:0] ev_data;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  logic [EW-1:0] q[$];
  logic [T-1:0] m_ts;
  logic [W-1:0] m_prev;
  bit m_primed, m_ovf;
  int m_drop;
  always #5 clk = ~clk;
  v_hier_qmon #(.WIDTH(W), .DEPTH(D), .TSW(T)) dut (
    .clk(clk),
    .reset_l(reset_l),
    .en(en),
    .qvec(qvec),
    .clr_ovf(clr_ovf),
    .ev_ready(ev_ready),
    .ev_valid(ev_valid),
    .ev_data(ev_data),
    .count(count),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    q.delete();
    m_ts = '0;
    m_prev = '0;
    m_primed = 0;
    m_ovf = 0;
    m_drop = 0;
  endtask
  task automatic model_step();
    logic [EW-1:0] rec;
    bit ev;
    ev = en && m_primed && qvec != m_prev;
    rec = {m_ts, qvec ^ m_prev, qvec};
    if (ev_ready && q.size() > 0) void'(q.pop_front());
    if (clr_ovf) begin
      m_ovf = 0;
      m_drop = 0;
    end
    if (ev) begin
      if (q.size() < D) q.push_back(rec);
      else begin
        m_ovf = 1;
        m_drop = m_drop < 255 ? m_drop + 1 : 255;
      end
    end
    if (en) begin
      m_prev = qvec;
      m_ts = m_ts + 1'b1;
    end
    m_primed = en;
  endtask
  always @(negedge clk) begin
    if (reset_l) begin
      chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
      chk("count", 32'(count), 32'(q.size()));
      chk("ev_data", 32'(ev_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask
  task automatic tog(int n);
    repeat (n) begin
      qvec[0] = ~qvec[0];
      tick();
    end
  endtask
  task automatic do_reset();
    reset_l = 0;
    model_clear();
    #1;
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_data", 32'(ev_data), 0);
    en = 0;
    qvec = '0;
    clr_ovf = 0;
    ev_ready = 0;
    @(posedge clk);
    #2;
    reset_l = 1;
  endtask
  initial begin
    #3;
    do_reset();
    en = 1;
    tick(10);
    chk("idle_valid", 32'(ev_valid), 0);
    chk("idle_count", 32'(count), 0);
    chk("idle_ovf", 32'(overflow), 0);
    do_reset();
    en = 1;
    ev_ready = 1;
    qvec = 4'h5;
    tick(3);
    qvec = 4'h7;
    tick();
    chk("single_valid", 32'(ev_valid), 1);
    chk("single_data", 32'(ev_data), 32'h0327);
    tick();
    chk("single_gone", 32'(ev_valid), 0);
    do_reset();
    en = 1;
    tick();
    tog(6);
    chk("burst_count", 32'(count), 4);
    chk("burst_ovf", 32'(overflow), 1);
    chk("burst_drop", 32'(drop_cnt), 2);
    en = 0;
    ev_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_ts", 32'(ev_data[EW-1 -: T]), 32'(i + 1));
      tick();
    end
    chk("drained", 32'(count), 0);
    do_reset();
    en = 1;
    tick();
    tog(4);
    chk("full_count", 32'(count), 4);
    ev_ready = 1;
    tog(1);
    ev_ready = 0;
    chk("swap_count", 32'(count), 4);
    chk("swap_drop", 32'(drop_cnt), 0);
    chk("swap_head_ts", 32'(ev_data[EW-1 -: T]), 2);
    tog(5);
    chk("drop5", 32'(drop_cnt), 5);
    clr_ovf = 1;
    tog(1);
    clr_ovf = 0;
    chk("clr_drop_ovf", 32'(overflow), 1);
    chk("clr_drop_cnt", 32'(drop_cnt), 1);
    en = 0;
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_cnt", 32'(drop_cnt), 0);
    en = 1;
    tick();
    tog(255);
    chk("sat_reach", 32'(drop_cnt), 255);
    tog(3);
    chk("sat_hold", 32'(drop_cnt), 255);
    do_reset();
    ev_ready = 1;
    en = 1;
    qvec = 4'h1;
    tick(2);
    en = 0;
    qvec = 4'h2;
    tick();
    qvec = 4'h9;
    tick();
    qvec = 4'hE;
    tick();
    en = 1;
    tick();
    chk("reen_quiet", 32'(ev_valid), 0);
    qvec = 4'hF;
    tick();
    chk("reen_data", 32'(ev_data), 32'h031F);
    ev_ready = 0;
    tick();
    tog(6);
    chk("pre_rst_ovf", 32'(overflow), 1);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 1) != 0) qvec = W'($urandom);
      ev_ready = i < 1000 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      clr_ovf = $urandom_range(0, 15) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
